// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation sequencing controller.
//   - cic_state_e : sequencer FSM states
//   - DefDecM / DefNStage : default decimation ratio and comb stage count
//   - cic_width() : counter/index width helper (never returns 0)
//   - DefCntW / DefSelW : widths derived from the defaults
package cic_pkg;

  localparam int unsigned DefDecM   = 128;
  localparam int unsigned DefNStage = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StComb = 2'd1,
    StIsop = 2'd2,
    StOut  = 2'd3
  } cic_state_e;

  // $clog2 of 1 is 0, which would give a zero-width vector.
  function automatic int unsigned cic_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefCntW = cic_width(DefDecM);
  localparam int unsigned DefSelW = cic_width(DefNStage);

endpackage

// File: rtl/cic_dec_cnt.sv
// Modulo-DecM input sample counter with registered decimation strobe.
// The counter never stalls; on the DecM-th sample it wraps to 0 and
// pulses dec_stb_o for exactly one cycle on the following cycle.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   sample_en_i  one-cycle strobe per input sample
//   dec_stb_o    registered one-cycle decimation strobe
module cic_dec_cnt
  import cic_pkg::*;
#(
  parameter int unsigned DecM = DefDecM
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sample_en_i,
  output logic dec_stb_o
);

  localparam int unsigned CntW = cic_width(DecM);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dec_stb_q, dec_stb_d;

  always_comb begin
    cnt_d     = cnt_q;
    dec_stb_d = 1'b0;
    if (sample_en_i) begin
      if (cnt_q == CntW'(DecM - 1)) begin
        cnt_d     = '0;
        dec_stb_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      dec_stb_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dec_stb_q <= dec_stb_d;
    end
  end

  assign dec_stb_o = dec_stb_q;

endmodule

// File: rtl/cic_seq_ctrl.sv
// Sequencing controller for the time-shared CIC decimation datapath.
// Counts samples (cic_dec_cnt), then on each decimation strobe steps the
// shared comb adder through NStage stages, optionally issues one ISOP
// compensation step, and holds out_valid_o until out_ready_i accepts it.
// A strobe arriving while busy is dropped and sets the sticky overrun flag,
// except when it coincides with the output handshake: then the FSM goes
// straight back to COMB.
// Configuration macro: CIC_ISOP_EN (defined -> ISOP step present;
// undefined -> COMB goes directly to OUT and isop_en_o is tied low).
// DecM must be at least NStage + 4.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   sample_en_i    input sample strobe
//   out_ready_i    downstream ready
//   dec_stb_o      decimated sample latched into comb input
//   comb_en_o      shared comb adder enable
//   comb_sel_o     active comb stage index (0 outside COMB)
//   isop_en_o      ISOP compensator step enable
//   out_valid_o    output word valid
//   busy_o         FSM not idle
//   overrun_o      sticky: a decimation strobe was dropped
module cic_seq_ctrl
  import cic_pkg::*;
#(
  parameter int unsigned  DecM   = DefDecM,
  parameter int unsigned  NStage = DefNStage,
  localparam int unsigned SelW   = cic_width(NStage)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            sample_en_i,
  input  logic            out_ready_i,
  output logic            dec_stb_o,
  output logic            comb_en_o,
  output logic [SelW-1:0] comb_sel_o,
  output logic            isop_en_o,
  output logic            out_valid_o,
  output logic            busy_o,
  output logic            overrun_o
);

  logic dec_stb;

  cic_dec_cnt #(
    .DecM(DecM)
  ) u_dec_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sample_en_i(sample_en_i),
    .dec_stb_o  (dec_stb)
  );

  cic_state_e      state_q, state_d;
  logic [SelW-1:0] comb_sel_q, comb_sel_d;
  logic            overrun_q, overrun_d;
  logic            comb_en_q, out_valid_q, busy_q;

  always_comb begin
    state_d    = state_q;
    comb_sel_d = '0;
    overrun_d  = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (dec_stb) begin
          state_d = StComb;
        end
      end
      StComb: begin
        if (comb_sel_q == SelW'(NStage - 1)) begin
`ifdef CIC_ISOP_EN
          state_d = StIsop;
`else
          state_d = StOut;
`endif
        end else begin
          comb_sel_d = comb_sel_q + SelW'(1);
        end
        if (dec_stb) begin
          overrun_d = 1'b1;
        end
      end
      StIsop: begin
        state_d = StOut;
        if (dec_stb) begin
          overrun_d = 1'b1;
        end
      end
      StOut: begin
        // out_valid_o is high throughout StOut, so ready alone completes it.
        if (out_ready_i) begin
          state_d = dec_stb ? StComb : StIdle;
        end else if (dec_stb) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      comb_sel_q  <= '0;
      overrun_q   <= 1'b0;
      comb_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comb_sel_q  <= comb_sel_d;
      overrun_q   <= overrun_d;
      comb_en_q   <= (state_d == StComb);
      out_valid_q <= (state_d == StOut);
      busy_q      <= (state_d != StIdle);
    end
  end

`ifdef CIC_ISOP_EN
  logic isop_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      isop_en_q <= 1'b0;
    end else begin
      isop_en_q <= (state_d == StIsop);
    end
  end

  assign isop_en_o = isop_en_q;
`else
  assign isop_en_o = 1'b0;
`endif

  assign dec_stb_o   = dec_stb;
  assign comb_en_o   = comb_en_q;
  assign comb_sel_o  = comb_sel_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_cic_seq_ctrl.sv
// Self-checking bench for cic_seq_ctrl (default DecM=128, NStage=6).
// A job-offset model predicts every output on every cycle; directed
// sequences add literal checks on cycle positions and sticky flags.
module tb_cic_seq_ctrl;

  localparam int M = 128;
  localparam int N = 6;
`ifdef CIC_ISOP_EN
  localparam int Isop = 1;
`else
  localparam int Isop = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       dec_stb, comb_en, isop_en, out_valid, busy, overrun;
  logic [2:0] comb_sel;

  cic_seq_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sample_en_i(sample_en),
    .out_ready_i(out_ready),
    .dec_stb_o  (dec_stb),
    .comb_en_o  (comb_en),
    .comb_sel_o (comb_sel),
    .isop_en_o  (isop_en),
    .out_valid_o(out_valid),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Model: a job starts on the cycle its strobe is consumed (m_s); everything
  // else is an offset from that cycle.
  int m_cnt = 0, m_s = 0, off = 0, e_sel = 0;
  bit m_stb = 0, m_job = 0, m_ovr = 0;
  bit e_comb, e_isop, e_out, hs;
  int n_stb = 0, n_hs = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_stb = 0; m_job = 0; m_s = 0; m_ovr = 0;
    end
    e_comb = 0; e_isop = 0; e_out = 0; e_sel = 0;
    if (m_job) begin
      off    = cyc - m_s;
      e_comb = (off >= 1) && (off <= N);
      if (e_comb) e_sel = off - 1;
      e_isop = (Isop == 1) && (off == N + 1);
      e_out  = (off >= N + 1 + Isop);
    end
    chk("m_dec_stb", dec_stb, m_stb);
    chk("m_comb_en", comb_en, e_comb);
    chk("m_comb_sel", comb_sel, e_sel);
    chk("m_isop_en", isop_en, e_isop);
    chk("m_out_valid", out_valid, e_out);
    chk("m_busy", busy, m_job);
    chk("m_overrun", overrun, m_ovr);
    if (dec_stb) n_stb++;
    if (out_valid && out_ready) n_hs++;
    if (rst_n) begin
      hs = e_out && out_ready;
      if (m_stb) begin
        if (!m_job || hs) begin
          m_job = 1; m_s = cyc;
        end else begin
          m_ovr = 1;
        end
      end else if (hs) begin
        m_job = 0;
      end
      m_stb = sample_en && (m_cnt == M - 1);
      if (sample_en) m_cnt = (m_cnt + 1) % M;
    end
  end

  task automatic step(input bit se, input bit rdy);
    @(posedge clk);
    #1;
    sample_en = se;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; sample_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_stb"}, dec_stb, 0);
    chk({nm, "_comb"}, comb_en, 0);
    chk({nm, "_sel"}, comb_sel, 0);
    chk({nm, "_isop"}, isop_en, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ovr"}, overrun, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int t, b_stb, b_hs;

  initial begin
    // Reset and one dense decimation period.
    do_reset();
    @(negedge clk);
    chk_all_zero("rst");
    for (int i = 0; i < M; i++) step(1, 1);
    t = cyc;
    step(0, 1);
    @(negedge clk);
    chk("t1_stb", dec_stb, 1);
    chk("t1_comb_early", comb_en, 0);
    for (int k = 0; k < N; k++) begin
      step(0, 1);
      @(negedge clk);
      chk("t1_comb", comb_en, 1);
      chk("t1_sel", comb_sel, k);
      chk("t1_busy", busy, 1);
    end
    step(0, 1);
    @(negedge clk);
`ifdef CIC_ISOP_EN
    chk("t1_isop", isop_en, 1);
    chk("t1_valid_early", out_valid, 0);
    step(0, 1);
    @(negedge clk);
`endif
    chk("t1_valid", out_valid, 1);
    chk("t1_isop_low", isop_en, 0);
    chk("t1_valid_pos", cyc - t, N + 2 + Isop);
    step(0, 1);
    @(negedge clk);
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_idle", busy, 0);

    // Sparse samples: two full periods, ready always high.
    b_stb = n_stb; b_hs = n_hs;
    repeat (2 * M) begin
      step(1, 1);
      repeat (3) step(0, 1);
    end
    repeat (12) step(0, 1);
    @(negedge clk);
    chk("t2_nstb", n_stb - b_stb, 2);
    chk("t2_nhs", n_hs - b_hs, 2);
    chk("t2_ovr", overrun, 0);
    chk("t2_idle", busy, 0);

    // Stalled output: the next strobe is dropped and overrun sticks.
    b_hs = n_hs;
    for (int i = 0; i < M; i++) step(1, 0);
    repeat (20) step(0, 0);
    @(negedge clk);
    chk("t3_wait_valid", out_valid, 1);
    chk("t3_ovr_pre", overrun, 0);
    for (int i = 0; i < M; i++) step(1, 0);
    repeat (3) step(0, 0);
    @(negedge clk);
    chk("t3_ovr", overrun, 1);
    chk("t3_valid_held", out_valid, 1);
    chk("t3_nhs0", n_hs - b_hs, 0);
    step(0, 1);
    @(negedge clk);
    chk("t3_hs_valid", out_valid, 1);
    step(0, 0);
    @(negedge clk);
    chk("t3_valid_drop", out_valid, 0);
    chk("t3_idle", busy, 0);
    chk("t3_ovr_sticky", overrun, 1);
    chk("t3_nhs1", n_hs - b_hs, 1);

    // Handshake coincident with the next strobe restarts COMB, no overrun.
    do_reset();
    @(negedge clk);
    chk("t4_ovr_cleared", overrun, 0);
    for (int i = 0; i < M; i++) step(1, 0);
    repeat (20) step(0, 0);
    for (int i = 0; i < M; i++) step(1, 0);
    step(0, 1);
    @(negedge clk);
    chk("t4_stb", dec_stb, 1);
    chk("t4_valid", out_valid, 1);
    step(0, 0);
    @(negedge clk);
    chk("t4_comb", comb_en, 1);
    chk("t4_sel0", comb_sel, 0);
    chk("t4_valid_drop", out_valid, 0);
    chk("t4_ovr", overrun, 0);
    repeat (12) step(0, 1);
    @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("t4_ovr_end", overrun, 0);

    // Asynchronous reset mid-COMB; counter restarts from zero.
    for (int i = 0; i < M; i++) step(1, 1);
    repeat (5) step(0, 1);
    @(negedge clk);
    chk("t5_sel3", comb_sel, 3);
    chk("t5_comb", comb_en, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sample_en = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_stb = n_stb;
    for (int i = 0; i < M - 1; i++) step(1, 1);
    repeat (4) step(0, 1);
    @(negedge clk);
    chk("t5_no_stb", n_stb - b_stb, 0);
    step(1, 1);
    step(0, 1);
    @(negedge clk);
    chk("t5_stb", dec_stb, 1);
    repeat (12) step(0, 1);
    @(negedge clk);
    chk("t5_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_seq_ctrl.md
# cic_seq_ctrl

Sequencing controller for the time-shared CIC decimation datapath in the bit-stream decimation filter. It counts input samples, raises the decimation strobe every `DEC_M` samples, and steps one shared comb adder through `N_STAGE` stages. It then optionally issues a single ISOP-compensation step and presents the result on a valid/ready output handshake. It sits between the integrator chain and the system output. It replaces free-running `ND`-driven sequencing with an explicit FSM that detects overrun.

## Interface
- `DEC_M`, 128, decimation ratio (samples per output); must be ≥ `N_STAGE`+4
- `N_STAGE`, 6, number of comb stages sequenced through the shared adder
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `sample_en`  in  1  one-cycle strobe per input sample (integrator update)
- `out_ready`  in  1  downstream accepts output when high
- `dec_stb`  out  1  one-cycle pulse: decimated sample latched into comb input
- `comb_en`  out  1  shared comb adder enable
- `comb_sel`  out  $clog2(N_STAGE)  active comb stage index
- `isop_en`  out  1  ISOP compensator step enable
- `out_valid`  out  1  output word valid
- `busy`  out  1  FSM not in IDLE
- `overrun`  out  1  sticky: a decimation strobe was dropped

## Operation
- Sample counter `cnt` runs 0..DEC_M-1 and increments on `sample_en`. On `sample_en` with `cnt`==DEC_M-1, it wraps to 0 and registers `dec_stb`=1 for the next cycle.
- FSM states: IDLE, COMB, ISOP, OUT.
- IDLE: on `dec_stb`, go to COMB with `comb_sel`=0.
- COMB: `comb_en`=1 and `comb_sel` increments each cycle. After `comb_sel`==N_STAGE-1, go to ISOP.
- ISOP: `isop_en`=1 for one cycle, then go to OUT.
- OUT: `out_valid`=1 until `out_valid`&&`out_ready`, then go to IDLE.
- Simultaneous handshake and `dec_stb` in OUT: the handshake completes and the FSM goes directly to COMB with `comb_sel`=0. No drop occurs.
- `dec_stb` in any non-IDLE state, without the case above: the decimated sample is dropped and `overrun` is set. `overrun` clears only on reset.
- `sample_en` keeps counting regardless of FSM state. The counter never stalls.
- `comb_en`, `isop_en`, `out_valid` are mutually exclusive. `comb_sel` is held at 0 outside COMB.
- Reset mid-operation: FSM returns to IDLE, `cnt`=0, and the in-flight sample is discarded.

## Timing
- Reset values: `dec_stb`=0, `comb_en`=0, `comb_sel`=0, `isop_en`=0, `out_valid`=0, `busy`=0, `overrun`=0, `cnt`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Cycle numbering starts with the M-th `sample_en` at cycle t:
  - `dec_stb` is high at t+1.
  - `comb_en` is high from t+2 to t+N_STAGE+1.
  - `isop_en` is high at t+N_STAGE+2.
  - `out_valid` rises at t+N_STAGE+3.
- With defaults: COMB runs t+2..t+7, ISOP at t+8, `out_valid` at t+9.
- `busy` is high from t+2 until the cycle after the handshake.

## Configuration
- `CIC_ISOP_EN` defined: ISOP state is present and behaves as above.
- `CIC_ISOP_EN` undefined:
  - The ISOP state is removed and COMB goes directly to OUT.
  - `isop_en` is tied to 0.
  - `out_valid` rises at t+N_STAGE+2.

## Structure
- Shared package `cic_pkg` holds:
  - state enum (IDLE/COMB/ISOP/OUT)
  - default `DEC_M`, `N_STAGE`
  - derived counter widths via $clog2
- Sub-module `cic_dec_cnt` implements the modulo-DEC_M sample counter and the registered `dec_stb` generator. The FSM and output registers live in the top.

## Test plan
- Reset, then 128 `sample_en` pulses (one per cycle), `out_ready`=1 → `dec_stb` at cycle 129, `comb_sel` 0..5 over 6 cycles, `isop_en` one cycle, one `out_valid` pulse at t+9.
- Sparse `sample_en` (one every 4 cycles), 256 samples, `out_ready`=1 → exactly 2 `dec_stb`, 2 output handshakes, `overrun`=0.
- `out_ready`=0 held for more than 128 samples after the first output → second `dec_stb` dropped, `overrun`=1 sticky; releasing `out_ready` gives one handshake, then IDLE.
- `out_ready` asserted on the same cycle as the next `dec_stb` while in OUT → handshake accepted, FSM to COMB next cycle with `comb_sel`=0, `overrun` stays 0.
- `rst` asserted low during COMB with `comb_sel`=3 → all outputs 0 immediately; after release, the next `dec_stb` needs a full 128 samples.
- Build without `CIC_ISOP_EN` → `isop_en` never high, `out_valid` at t+8.
